paint_scheduler: RTL and testbench

// Frame-level sequencer between runner and blitter. On each buffer swap:
// - snapshots the RENDER_SLOTS sprite/pos table;
// - issues one clear command, then one blit command per visible slot, in slot order (0 first = back-most);
// - requests a back-buffer swap at the next vsync;
// - raises painter_finished, which steps the runner's game loop.

---
 rtl/paint_scheduler_pkg.sv | 36 +++
 rtl/paint_scheduler_slot_visible.sv | 30 +++
 rtl/paint_scheduler.sv | 150 +++++++++++++++
 tb/tb_paint_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_scheduler_pkg.sv
// Shared types, screen defaults and FSM state codes for the paint scheduler.
package paint_scheduler_pkg;

  localparam int SCREEN_W_DEF = 1280;
  localparam int SCREEN_H_DEF = 300;

  // Same bit layout as the runner's render table: unsigned atlas rect, signed screen pos.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } pos_t;

  typedef enum logic { OP_CLEAR = 1'b0, OP_BLIT = 1'b1 } blit_op_t;

  typedef struct packed {
    blit_op_t op;
    sprite_t  sprite;
    pos_t     pos;
  } blit_cmd_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SNAPSHOT = 3'd1;
  localparam logic [2:0] S_CLEAR    = 3'd2;
  localparam logic [2:0] S_SCAN     = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

endpackage

// File: rtl/paint_scheduler_slot_visible.sv
// Combinational skip test for one render slot. Only the sprite size and screen
// position matter; atlas coordinates never affect visibility.
module paint_scheduler_slot_visible
  import paint_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [11:0] i_w,
  input  logic [11:0] i_h,
  input  pos_t        i_pos,
  output logic        o_visible
);

  localparam logic signed [12:0] LIM_X = 13'(SCREEN_W);
  localparam logic signed [12:0] LIM_Y = 13'(SCREEN_H);

  // 13-bit signed so a negative position plus a large size cannot wrap.
  logic signed [12:0] w_x, w_y, w_xe, w_ye;

  assign w_x  = {i_pos.x[11], i_pos.x};
  assign w_y  = {i_pos.y[11], i_pos.y};
  assign w_xe = w_x + $signed({1'b0, i_w});
  assign w_ye = w_y + $signed({1'b0, i_h});

  assign o_visible = (i_w != '0) && (i_h != '0) &&
                     (w_x < LIM_X) && (w_y < LIM_Y) &&
                     (w_xe > 13'sd0) && (w_ye > 13'sd0);

endmodule

// File: rtl/paint_scheduler.sv
// Frame sequencer: snapshot the render table, emit CLEAR plus one BLIT per
// visible slot, wait for the blitter to drain, then swap on the next vsync.
module paint_scheduler
  import paint_scheduler_pkg::*;
#(
  parameter int SLOTS    = 32,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int OVR_W    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_vsync,
  input  sprite_t [SLOTS-1:0]    i_sprite,
  input  pos_t    [SLOTS-1:0]    i_pos,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  output blit_cmd_t              o_cmd,
  input  logic                   i_blit_idle,
  output logic                   o_swap,
  output logic                   o_painter_finished,
  output logic [OVR_W-1:0]       o_frame_overruns
);

  localparam int IDX_W = $clog2(SLOTS);

  logic [2:0]             r_state;
  logic                   r_first;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_cmd_valid;
  blit_cmd_t              r_cmd;
  logic                   r_swap;
  logic                   r_pf;
  logic [OVR_W-1:0]       r_ovr;
  sprite_t [SLOTS-1:0]    r_sh_sprite;
  pos_t    [SLOTS-1:0]    r_sh_pos;

  sprite_t                w_cur_sprite;
  pos_t                   w_cur_pos;
  logic                   w_vis;
  logic                   w_last;
  logic                   w_ovr_ev;

  assign w_cur_sprite = r_sh_sprite[r_idx];
  assign w_cur_pos    = r_sh_pos[r_idx];
  assign w_last       = (r_idx == IDX_W'(SLOTS - 1));
  // A vsync while a frame is still being drawn is counted and otherwise ignored.
  assign w_ovr_ev     = i_vsync && (r_state != S_IDLE) && (r_state != S_DONE);

  paint_scheduler_slot_visible #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_vis (
    .i_w       (w_cur_sprite.w),
    .i_h       (w_cur_sprite.h),
    .i_pos     (w_cur_pos),
    .o_visible (w_vis)
  );

  // Frame FSM, command handshake, swap/finished flags and overrun counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_idx       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_swap      <= 1'b0;
      r_pf        <= 1'b0;
      r_ovr       <= '0;
    end else begin
      r_swap <= 1'b0;
      if (w_ovr_ev && (r_ovr != {OVR_W{1'b1}}))
        r_ovr <= r_ovr + 1'b1;
      case (r_state)
        S_IDLE: begin
          // First frame after reset starts without waiting for vsync.
          if (i_vsync || r_first) begin
            r_first <= 1'b0;
            r_state <= S_SNAPSHOT;
          end
        end
        S_SNAPSHOT: begin
          r_pf        <= 1'b0;
          r_cmd_valid <= 1'b1;
          r_cmd       <= '{OP_CLEAR, sprite_t'('0), pos_t'('0)};
          r_state     <= S_CLEAR;
        end
        S_CLEAR: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_idx       <= '0;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_vis) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= '{OP_BLIT, w_cur_sprite, w_cur_pos};
            r_state     <= S_ISSUE;
          end else if (w_last) begin
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_ISSUE: begin
          // cmd is held untouched until the blitter takes it.
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        S_DRAIN: begin
          if (i_blit_idle) begin
            r_pf    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_vsync) begin
            r_swap  <= 1'b1;
            r_state <= S_SNAPSHOT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shadow copy of the render table; only read after SNAPSHOT so needs no reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_SNAPSHOT) begin
      r_sh_sprite <= i_sprite;
      r_sh_pos    <= i_pos;
    end
  end

  assign o_cmd_valid        = r_cmd_valid;
  assign o_cmd              = r_cmd;
  assign o_swap             = r_swap;
  assign o_painter_finished = r_pf;
  assign o_frame_overruns   = r_ovr;

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler: expected command streams come from a
// table-level visibility model; a monitor checks every transfer and stall.
module tb_paint_scheduler;
  import paint_scheduler_pkg::*;

  localparam int SLOTS = 32;

  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, cmd_ready = 1'b0, blit_idle = 1'b1;
  sprite_t [SLOTS-1:0] sprite;
  pos_t    [SLOTS-1:0] pos;
  logic      cmd_valid, swap, pf;
  blit_cmd_t cmd;
  logic [7:0] ovr;

  int checks = 0, errors = 0;
  blit_cmd_t exp_q[$];
  int n_xfer = 0, swap_cnt = 0, rdy_mode = 0, rdy_cnt = 0, busy = 0;
  blit_cmd_t last_cmd, cmd_prev;
  bit stall_prev = 0, stop = 0;

  always #5 clk = ~clk;

  paint_scheduler #(.SLOTS(SLOTS), .SCREEN_W(1280), .SCREEN_H(300), .OVR_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_sprite(sprite), .i_pos(pos),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd(cmd),
    .i_blit_idle(blit_idle), .o_swap(swap), .o_painter_finished(pf),
    .o_frame_overruns(ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_cmd(input string name, input blit_cmd_t act, input blit_cmd_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  function automatic blit_cmd_t mk(input blit_op_t op, input int sx, input int sy,
                                   input int w, input int h, input int px, input int py);
    blit_cmd_t c;
    c.op = op;
    c.sprite.x = 12'(sx); c.sprite.y = 12'(sy); c.sprite.w = 12'(w); c.sprite.h = 12'(h);
    c.pos.x = 12'(px); c.pos.y = 12'(py);
    return c;
  endfunction

  // Visibility from the rules, in plain integer arithmetic.
  function automatic bit vis(input sprite_t s, input pos_t p);
    int x, y, w, h;
    x = $signed(p.x); y = $signed(p.y); w = int'(s.w); h = int'(s.h);
    return (w != 0) && (h != 0) && (x < 1280) && (y < 300) && (x + w > 0) && (y + h > 0);
  endfunction

  task automatic clear_table;
    for (int i = 0; i < SLOTS; i++) begin sprite[i] = '0; pos[i] = '0; end
  endtask

  task automatic set_slot(input int i, input int sx, input int sy, input int w, input int h,
                          input int px, input int py);
    blit_cmd_t c;
    c = mk(OP_BLIT, sx, sy, w, h, px, py);
    sprite[i] = c.sprite; pos[i] = c.pos;
  endtask

  // Expected stream for the table as it stands now (the snapshot).
  task automatic build_exp;
    exp_q.delete();
    exp_q.push_back(mk(OP_CLEAR, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < SLOTS; i++)
      if (vis(sprite[i], pos[i])) exp_q.push_back('{OP_BLIT, sprite[i], pos[i]});
    n_xfer = 0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_vsync(input bit exp_swap);
    vsync = 1'b1; tick; vsync = 1'b0;
    chk("swap_after_vsync", swap, exp_swap);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 800; i++) begin
      tick;
      if (pf) break;
    end
    chk(name, pf, 1);
    chk("stream_consumed", exp_q.size(), 0);
  endtask

  // Ready pattern and a small blitter busy model.
  initial forever begin
    @(negedge clk);
    if (cmd_valid && cmd_ready) busy = 3;
    @(posedge clk); #1;
    rdy_cnt++;
    case (rdy_mode)
      0:       cmd_ready = 1'b1;
      1:       cmd_ready = (rdy_cnt % 3 == 0);
      default: cmd_ready = 1'b0;
    endcase
    if (busy > 0) busy--;
    blit_idle = (busy == 0);
  end

  // Compare process: every transfer against the model, every stall for stability.
  initial forever begin
    @(negedge clk);
    if (swap === 1'b1) swap_cnt++;
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) begin
        checks++;
        if (!(cmd_valid === 1'b1 && cmd === cmd_prev)) begin
          errors++;
          $display("FAIL stall_stable: actual valid=%b cmd=%h, required valid=1 cmd=%h",
                   cmd_valid, cmd, cmd_prev);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_cmd: actual %h, required none", cmd);
        end else chk_cmd("cmd_stream", cmd, exp_q.pop_front());
        n_xfer++;
        last_cmd = cmd;
      end
      stall_prev = cmd_valid && !cmd_ready;
      cmd_prev = cmd;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    // 1: reset state, then auto-start frame with only slot 18
    clear_table;
    set_slot(18, 1678, 2, 88, 94, 100, 180);
    rdy_mode = 0;
    repeat (3) tick;
    chk("rst_valid", cmd_valid, 0);
    chk_cmd("rst_cmd", cmd, '0);
    chk("rst_swap", swap, 0);
    chk("rst_pf", pf, 0);
    chk("rst_ovr", ovr, 0);
    build_exp;
    rst = 1'b0;
    wait_done("t1_done");
    chk("t1_nxfer", n_xfer, 2);
    chk_cmd("t1_blit", last_cmd, mk(OP_BLIT, 1678, 2, 88, 94, 100, 180));
    repeat (10) tick;
    chk("t1_noswap", swap_cnt, 0);
    chk("t1_pf_hold", pf, 1);

    // 2: slots 0,4,11 visible, ready 1-in-3
    clear_table;
    set_slot(0, 0, 0, 16, 16, 0, 0);
    set_slot(2, 5, 5, 5, 0, 10, 10);
    set_slot(4, 16, 0, 32, 8, 640, 150);
    set_slot(11, 100, 50, 8, 8, 1272, 292);
    rdy_mode = 1;
    build_exp;
    s0 = swap_cnt;
    pulse_vsync(1);
    wait_done("t2_done");
    chk("t2_nxfer", n_xfer, 4);
    chk_cmd("t2_last", last_cmd, mk(OP_BLIT, 100, 50, 8, 8, 1272, 292));
    chk("t2_swap_once", swap_cnt - s0, 1);

    // 3: edge-of-screen boundaries
    clear_table;
    set_slot(5, 0, 0, 40, 10, -40, 10);
    set_slot(6, 0, 0, 10, 10, 1280, 10);
    set_slot(7, 0, 0, 40, 10, -39, 10);
    set_slot(8, 0, 0, 10, 10, 5, 300);
    set_slot(9, 0, 0, 10, 10, 5, -10);
    set_slot(10, 0, 0, 10, 10, 0, -9);
    rdy_mode = 0;
    build_exp;
    s0 = swap_cnt;
    pulse_vsync(1);
    wait_done("t3_done");
    chk("t3_nxfer", n_xfer, 3);
    chk_cmd("t3_last", last_cmd, mk(OP_BLIT, 0, 0, 10, 10, 0, -9));
    chk("t3_swap_once", swap_cnt - s0, 1);

    // 4: runner scribbles every cycle after SNAPSHOT
    clear_table;
    set_slot(1, 3, 4, 20, 20, 200, 100);
    set_slot(2, 7, 8, 30, 30, 400, 200);
    build_exp;
    pulse_vsync(1);
    stop = 0;
    fork
      begin
        while (!stop) begin
          tick;
          for (int i = 0; i < SLOTS; i++) begin
            sprite[i] = 48'({$urandom, $urandom});
            pos[i] = 24'($urandom);
          end
        end
      end
    join_none
    wait_done("t4_done");
    stop = 1;
    tick; tick;
    chk("t4_nxfer", n_xfer, 3);

    // 5: stalled frame across 3 vsyncs
    clear_table;
    set_slot(3, 1, 1, 10, 10, 50, 50);
    rdy_mode = 2;
    build_exp;
    s0 = swap_cnt;
    pulse_vsync(1);
    repeat (3) begin
      repeat (5) tick;
      pulse_vsync(0);
    end
    repeat (3) tick;
    chk("t5_ovr", ovr, 3);
    chk("t5_pf_low", pf, 0);
    chk("t5_no_extra_swap", swap_cnt - s0, 1);
    rdy_mode = 0;
    wait_done("t5_done");
    chk("t5_nxfer", n_xfer, 2);

    // 6: reset while a BLIT is stalled in the handshake
    clear_table;
    set_slot(30, 2, 2, 12, 12, 60, 60);
    build_exp;
    pulse_vsync(1);
    for (int i = 0; i < 50 && n_xfer < 1; i++) tick;
    rdy_mode = 2;
    for (int i = 0; i < 100 && !(cmd_valid && cmd.op == OP_BLIT); i++) tick;
    chk("t6_in_issue", cmd_valid && cmd.op == OP_BLIT, 1);
    rst = 1'b1;
    tick;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_pf", pf, 0);
    chk("t6_rst_ovr", ovr, 0);
    clear_table;
    set_slot(1, 9, 9, 4, 4, 10, 10);
    build_exp;
    rdy_mode = 0;
    tick;
    rst = 1'b0;
    wait_done("t6_done");
    chk("t6_nxfer", n_xfer, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
